// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared fetch-stage types, next-PC select codes and reset PC
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction memory request/ack bus between fetch unit and memory
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// rtl/pc_fetch_unit_next_pc_calc.sv - combinational redirect target for branch, J and JR
module next_pc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [1:0]  sel_in,
  input  logic [31:0] if_pc4,
  input  logic [15:0] branch_offset,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_addr,
  output logic [31:0] target,
  output logic        jr_misaligned
);

  // Targets are relative to the decode-stage instruction's pc+4, not the fetch pc.
  always_comb begin
    target        = if_pc4;
    jr_misaligned = 1'b0;
    case (sel_in)
      SEL_BR: target = if_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
      SEL_J:  target = {if_pc4[31:28], jump_target, 2'b00};
      SEL_JR: begin
        // The low bits are forced to zero so the jump still lands on a word.
        target        = {jr_addr[31:2], 2'b00};
        jr_misaligned = |jr_addr[1:0];
      end
      default: target = if_pc4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, instruction fetch sequencing and IF/ID register
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  pc_fetch_unit_if.master        imem,
  input  logic [1:0]             sel_in,
  input  logic [15:0]            branch_offset,
  input  logic [25:0]            jump_target,
  input  logic [31:0]            jr_addr,
  input  logic                   stall,
  output logic                   if_valid,
  output logic [31:0]            if_instr,
  output logic [31:0]            if_pc4,
  output logic                   misalign_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc4_q, hold_pc4_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc4_q, if_pc4_d;
  logic         misalign_err_q, misalign_err_d;

  logic [31:0]  target;
  logic         jr_misaligned;
  logic         redirect;
  logic [31:0]  pc_plus4;

  next_pc_calc u_next_pc_calc (
    .sel_in        (sel_in),
    .if_pc4        (if_pc4_q),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .jr_addr       (jr_addr),
    .target        (target),
    .jr_misaligned (jr_misaligned)
  );

  // A redirect only counts when decode holds a real instruction and is consuming it.
  assign redirect = if_valid_q && !stall && (sel_in != SEL_SEQ);
  assign pc_plus4 = pc_q + 32'd4;

  // The request stays up in DRAIN so the outstanding access can complete and be thrown away.
  assign imem.imem_req  = (state_q != ST_HOLD);
  assign imem.imem_addr = pc_q;

  assign if_valid     = if_valid_q;
  assign if_instr     = if_instr_q;
  assign if_pc4       = if_pc4_q;
  assign misalign_err = misalign_err_q;

  // Next-state and datapath updates; redirect beats stall, stall beats advance.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    redir_pc_d     = redir_pc_q;
    hold_instr_d   = hold_instr_q;
    hold_pc4_d     = hold_pc4_q;
    if_valid_d     = if_valid_q;
    if_instr_d     = if_instr_q;
    if_pc4_d       = if_pc4_q;
    misalign_err_d = redirect && jr_misaligned;

    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          if (imem.imem_ack) begin
            pc_d = target;
          end else begin
            redir_pc_d = target;
            state_d    = ST_DRAIN;
          end
        end else if (stall) begin
          if (imem.imem_ack) begin
            hold_instr_d = imem.imem_rdata;
            hold_pc4_d   = pc_plus4;
            pc_d         = pc_plus4;
            state_d      = ST_HOLD;
          end
        end else if (imem.imem_ack) begin
          if_instr_d = imem.imem_rdata;
          if_pc4_d   = pc_plus4;
          if_valid_d = 1'b1;
          pc_d       = pc_plus4;
        end else begin
          if_valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (!stall) begin
          state_d = ST_FETCH;
          if (redirect) begin
            pc_d       = target;
            if_valid_d = 1'b0;
          end else begin
            if_instr_d = hold_instr_q;
            if_pc4_d   = hold_pc4_q;
            if_valid_d = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (imem.imem_ack) begin
          pc_d    = redir_pc_q;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_FETCH;
      pc_q           <= RESET_PC;
      redir_pc_q     <= 32'd0;
      hold_instr_q   <= 32'd0;
      hold_pc4_q     <= 32'd0;
      if_valid_q     <= 1'b0;
      if_instr_q     <= 32'd0;
      if_pc4_q       <= 32'd0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      redir_pc_q     <= redir_pc_d;
      hold_instr_q   <= hold_instr_d;
      hold_pc4_q     <= hold_pc4_d;
      if_valid_q     <= if_valid_d;
      if_instr_q     <= if_instr_d;
      if_pc4_q       <= if_pc4_d;
      misalign_err_q <= misalign_err_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit against a behavioural model
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel_in = 2'b00;
  logic [15:0] branch_offset = 16'd0;
  logic [25:0] jump_target = 26'd0;
  logic [31:0] jr_addr = 32'd0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  pc_fetch_unit_if imem_bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem_bus.master),
    .sel_in        (sel_in),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .jr_addr       (jr_addr),
    .stall         (stall),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc4        (if_pc4),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of parked fetches and a queue of pending redirect targets.
  logic [31:0] m_pc = 32'd0;
  logic        m_if_valid = 1'b0;
  logic [31:0] m_if_instr = 32'd0;
  logic [31:0] m_if_pc4 = 32'd0;
  logic        m_mis = 1'b0;
  logic [63:0] held[$];
  logic [31:0] pending[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0;
    m_if_valid = 1'b0;
    m_if_instr = 32'd0;
    m_if_pc4 = 32'd0;
    m_mis = 1'b0;
    held.delete();
    pending.delete();
  endtask

  task automatic model_clock();
    logic        redir;
    logic [31:0] t;
    logic signed [31:0] soff;
    logic [63:0] ent;
    redir = m_if_valid && !stall && (sel_in != 2'b00);
    soff = 32'($signed(branch_offset));
    case (sel_in)
      2'b01:   t = m_if_pc4 + 32'(soff * 4);
      2'b10:   t = (m_if_pc4 & 32'hF000_0000) + 32'(jump_target) * 32'd4;
      2'b11:   t = jr_addr & 32'hFFFF_FFFC;
      default: t = m_if_pc4;
    endcase
    m_mis = redir && (sel_in == 2'b11) && (jr_addr % 4 != 0);
    if (held.size() != 0) begin
      if (!stall) begin
        if (redir) begin
          held.delete();
          m_pc = t;
          m_if_valid = 1'b0;
        end else begin
          ent = held.pop_front();
          m_if_instr = ent[63:32];
          m_if_pc4 = ent[31:0];
          m_if_valid = 1'b1;
        end
      end
    end else if (pending.size() != 0) begin
      if (imem_bus.imem_ack) m_pc = pending.pop_front();
    end else if (redir) begin
      m_if_valid = 1'b0;
      if (imem_bus.imem_ack) m_pc = t;
      else pending.push_back(t);
    end else if (imem_bus.imem_ack) begin
      if (stall) begin
        held.push_back({imem_bus.imem_rdata, m_pc + 32'd4});
      end else begin
        m_if_instr = imem_bus.imem_rdata;
        m_if_pc4 = m_pc + 32'd4;
        m_if_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_if_valid = 1'b0;
    end
  endtask

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_imem_req", {31'd0, imem_bus.imem_req}, {31'd0, held.size() == 0});
      if (held.size() == 0) check("cyc_imem_addr", imem_bus.imem_addr, m_pc);
      check("cyc_if_valid", {31'd0, if_valid}, {31'd0, m_if_valid});
      check("cyc_if_instr", if_instr, m_if_instr);
      check("cyc_if_pc4", if_pc4, m_if_pc4);
      check("cyc_misalign", {31'd0, misalign_err}, {31'd0, m_mis});
    end
  end

  task automatic step(input logic [1:0] s, input logic [15:0] off, input logic [25:0] tgt,
                      input logic [31:0] jr, input logic stl, input logic ack, input logic [31:0] rd);
    sel_in = s;
    branch_offset = off;
    jump_target = tgt;
    jr_addr = jr;
    stall = stl;
    imem_bus.imem_ack = ack;
    imem_bus.imem_rdata = rd;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_addr", imem_bus.imem_addr, 32'h0);
    check("rst_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_pc4", if_pc4, 32'd0);
    rst = 1'b0;

    // Zero-wait sequential fetch.
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", imem_bus.imem_addr, 32'(4 * i));
      step(2'b00, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1, 32'h1000_0000 + 32'(i));
      check("seq_pc4", if_pc4, 32'(4 * (i + 1)));
      check("seq_valid", {31'd0, if_valid}, 32'd1);
      check("seq_instr", if_instr, 32'h1000_0000 + 32'(i));
    end

    // Backward branch from if_pc4 = 0x100.
    step(2'b11, 16'd0, 26'd0, 32'h0000_00FC, 1'b0, 1'b1, 32'h0);
    check("jr_fc_addr", imem_bus.imem_addr, 32'h0000_00FC);
    step(2'b00, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1, 32'hAAAA_0001);
    check("br_pre_pc4", if_pc4, 32'h0000_0100);
    step(2'b01, 16'hFFFE, 26'd0, 32'd0, 1'b0, 1'b1, 32'hAAAA_0002);
    check("br_addr", imem_bus.imem_addr, 32'h0000_00F8);
    check("br_bubble", {31'd0, if_valid}, 32'd0);
    step(2'b00, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1, 32'hAAAA_0003);
    check("br_refill", {31'd0, if_valid}, 32'd1);
    check("br_refill_pc4", if_pc4, 32'h0000_00FC);

    // J keeps the upper nibble of if_pc4.
    step(2'b11, 16'd0, 26'd0, 32'h4000_000C, 1'b0, 1'b1, 32'h0);
    step(2'b00, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1, 32'hBBBB_0001);
    check("j_pre_pc4", if_pc4, 32'h4000_0010);
    step(2'b10, 16'd0, 26'h000_0040, 32'd0, 1'b0, 1'b1, 32'hBBBB_0002);
    check("j_addr", imem_bus.imem_addr, 32'h4000_0100);
    step(2'b00, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1, 32'hBBBB_0003);
    check("j_pc4", if_pc4, 32'h4000_0104);

    // Misaligned JR while the access is still outstanding.
    step(2'b11, 16'd0, 26'd0, 32'h0000_0203, 1'b0, 1'b0, 32'h0);
    check("jr_mis", {31'd0, misalign_err}, 32'd1);
    check("jr_drain_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check("jr_drain_addr", imem_bus.imem_addr, 32'h4000_0104);
    step(2'b00, 16'd0, 26'd0, 32'd0, 1'b0, 1'b0, 32'h0);
    check("jr_mis_pulse", {31'd0, misalign_err}, 32'd0);
    step(2'b00, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1, 32'h5555_5555);
    check("jr_post_addr", imem_bus.imem_addr, 32'h0000_0200);
    check("jr_post_valid", {31'd0, if_valid}, 32'd0);

    // Stall while a fetch completes.
    step(2'b00, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1, 32'h0000_1111);
    check("st_pre_instr", if_instr, 32'h0000_1111);
    step(2'b00, 16'd0, 26'd0, 32'd0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check("st_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
    check("st_ifid_hold", if_instr, 32'h0000_1111);
    step(2'b00, 16'd0, 26'd0, 32'd0, 1'b1, 1'b0, 32'h0);
    check("st_still_hold", if_pc4, 32'h0000_0204);
    step(2'b00, 16'd0, 26'd0, 32'd0, 1'b0, 1'b0, 32'h0);
    check("st_release_instr", if_instr, 32'hDEAD_BEEF);
    check("st_release_pc4", if_pc4, 32'h0000_0208);
    check("st_release_addr", imem_bus.imem_addr, 32'h0000_0208);

    // Redirect taken out of HOLD drops the parked fetch.
    step(2'b00, 16'd0, 26'd0, 32'd0, 1'b1, 1'b1, 32'h0000_CAFE);
    step(2'b01, 16'h0004, 26'd0, 32'd0, 1'b0, 1'b0, 32'h0);
    check("hold_redir_addr", imem_bus.imem_addr, 32'h0000_0218);
    check("hold_redir_valid", {31'd0, if_valid}, 32'd0);

    // Select ignored while IF/ID is empty, and while stalled.
    step(2'b11, 16'd0, 26'd0, 32'h0000_0300, 1'b0, 1'b1, 32'h0000_2222);
    check("ign_invalid_addr", imem_bus.imem_addr, 32'h0000_021C);
    check("ign_invalid_instr", if_instr, 32'h0000_2222);
    step(2'b11, 16'd0, 26'd0, 32'h0000_0300, 1'b1, 1'b0, 32'h0);
    check("ign_stall_addr", imem_bus.imem_addr, 32'h0000_021C);
    check("ign_stall_valid", {31'd0, if_valid}, 32'd1);

    // Reset asserted mid-DRAIN takes effect without a clock edge.
    step(2'b11, 16'd0, 26'd0, 32'h0000_0401, 1'b0, 1'b0, 32'h0);
    check("pre_rst_mis", {31'd0, misalign_err}, 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_addr", imem_bus.imem_addr, 32'h0);
    check("async_rst_valid", {31'd0, if_valid}, 32'd0);
    check("async_rst_pc4", if_pc4, 32'd0);
    check("async_rst_instr", if_instr, 32'd0);
    check("async_rst_mis", {31'd0, misalign_err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_req", {31'd0, imem_bus.imem_req}, 32'd1);
    step(2'b00, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1, 32'h0000_3333);
    check("post_rst_addr", imem_bus.imem_addr, 32'h0000_0004);
    check("post_rst_pc4", if_pc4, 32'h0000_0004);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have ports: clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have ports: rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports: sel_in, input, 2, next-PC select from branch/jump control (00 seq, 01 branch, 10 J, 11 JR).
REQ-005 SHALL have ports: branch_offset, input, 16, signed word offset of the decode-stage branch.
REQ-006 SHALL have ports: jump_target, input, 26, J-format target field.
REQ-007 SHALL have ports: jr_addr, input, 32, register value for JR.
REQ-008 SHALL have ports: stall, input, 1, decode not accepting; IF/ID contents hold.
REQ-009 SHALL have ports: imem_req / imem_addr, output, 1 / 32, instruction memory request and address.
REQ-010 SHALL have ports: imem_ack / imem_rdata, input, 1 / 32, one-cycle completion pulse and data.
REQ-011 SHALL have ports: if_valid / if_instr / if_pc4, output, 1 / 32 / 32, IF/ID register: valid, instruction, fetch address + 4.
REQ-012 SHALL have ports: misalign_err, output, 1, one-cycle pulse on misaligned JR target.

Function
REQ-013 SHALL implement states FETCH, HOLD, DRAIN; imem_req = 1 in FETCH and DRAIN, 0 in HOLD; imem_addr = pc register, stable while imem_req is high.
REQ-014 SHALL form the redirect target from if_pc4: 01 -> if_pc4 + (sign-extended branch_offset << 2), mod 2^32; 10 -> {if_pc4[31:28], jump_target, 2'b00}; 11 -> {jr_addr[31:2], 2'b00}.
REQ-015 SHALL accept a redirect only when if_valid=1, stall=0, sel_in!=00; sel_in is ignored otherwise.
REQ-016 SHALL, in FETCH with imem_ack=1, stall=0 and no redirect, load if_instr<=imem_rdata, if_pc4<=pc+4, if_valid<=1, pc<=pc+4; remain FETCH (one instruction per cycle at zero-wait memory).
REQ-017 SHALL, in FETCH with imem_ack=0 and stall=0, clear if_valid (bubble).
REQ-018 SHALL, in FETCH with imem_ack=1 and stall=1, latch imem_rdata and pc+4 into a hold buffer, leave IF/ID unchanged, pc<=pc+4, go HOLD.
REQ-019 SHALL, in HOLD with stall=0, move the hold buffer into IF/ID with if_valid<=1 and go FETCH.
REQ-020 SHALL, on a redirect in FETCH with imem_ack=1, discard imem_rdata, pc<=target, if_valid<=0, remain FETCH.
REQ-021 SHALL, on a redirect in FETCH with imem_ack=0, store target in redir_pc, if_valid<=0, go DRAIN; in DRAIN, on imem_ack discard data, pc<=redir_pc, go FETCH.
REQ-022 SHALL, on a redirect in HOLD, discard the hold buffer, pc<=target, if_valid<=0, go FETCH.
REQ-023 SHALL pulse misalign_err for one cycle when a JR redirect is accepted with jr_addr[1:0]!=00; the redirect still proceeds with bits cleared.
REQ-024 SHALL give no priority conflict: within one cycle redirect outranks normal advance; stall outranks advance.

Reset
REQ-025 SHALL, on rst high, asynchronously set pc=RESET_PC, state=FETCH, if_valid=0, if_instr=0, if_pc4=0, misalign_err=0, redir_pc=0, hold buffer=0.
REQ-026 SHALL, on rst release mid memory transaction, reissue a fresh request at RESET_PC; the memory side tolerates the abandoned request.

Structure
REQ-027 SHALL place the state enum, sel codes (SEL_SEQ, SEL_BR, SEL_J, SEL_JR) and RESET_PC default in the shared CPU package.
REQ-028 SHALL put target arithmetic in one combinational sub-module, next_pc_calc.

Verification
REQ-029 SHALL cover: reset, zero-wait ack every cycle -> imem_addr 0,4,8,C; if_pc4 4,8,C,10 with if_valid=1.
REQ-030 SHALL cover: if_pc4=0x100, sel_in=01, offset=0xFFFE -> next imem_addr 0x0F8, if_valid=0 one cycle.
REQ-031 SHALL cover: if_pc4=0x40000010, sel_in=10, target=0x0000040 -> imem_addr 0x40000100.
REQ-032 SHALL cover: sel_in=11, jr_addr=0x203 while ack outstanding -> DRAIN, misalign_err one cycle, after ack imem_addr 0x200.
REQ-033 SHALL cover: stall=1 with ack of 0xDEADBEEF -> HOLD, imem_req=0, IF/ID unchanged; stall release -> if_instr=0xDEADBEEF.
REQ-034 SHALL cover: rst asserted mid-DRAIN -> all outputs reset same cycle, next imem_addr=RESET_PC.
